// File: rtl/cntr12_pkg.sv
// ============================================================================
// Module      : cntr12_pkg
// Description : Shared state encoding, default modulus and q-width helper for
//               the mod-12 run controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cntr12_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int C_MODULUS = 12;

    // Smallest width that holds 0..modulus-1, never narrower than one bit
    function automatic int calc_q_w(input int modulus);
        return (modulus > 2) ? $clog2(modulus) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ============================================================================
// Module      : mod_n_counter
// Description : Modulo-N up counter with clear, clamped load and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_counter
    import cntr12_pkg::*;
#(
    parameter int MODULUS = C_MODULUS,
    parameter int Q_W     = calc_q_w(MODULUS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           clr,
    input  logic           load,
    input  logic [Q_W-1:0] load_val,
    output logic [Q_W-1:0] q,
    output logic           wrap
);

    localparam logic [Q_W-1:0] c_max = Q_W'(MODULUS - 1);

    logic [Q_W-1:0] r_q;
    logic           w_at_max;

    assign w_at_max = (r_q == c_max);
    assign wrap     = en && w_at_max && !clr && !load;
    assign q        = r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= (load_val > c_max) ? c_max : load_val;
        end else if (en) begin
            r_q <= w_at_max ? '0 : r_q + Q_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cntr12_ctrl.sv
// ============================================================================
// Module      : cntr12_ctrl
// Description : Run controller for the mod-12 counter: programmable wrap
//               count, pause/step/abort and done/done_ack handshake.
//               Optional q load enabled by defining CNTR12_LOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr12_ctrl
    import cntr12_pkg::*;
#(
    parameter  int MODULUS = C_MODULUS,
    parameter  int WRAP_W  = 8,
    localparam int Q_W     = calc_q_w(MODULUS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic [WRAP_W-1:0] num_wraps,
`ifdef CNTR12_LOAD_EN
    input  logic              load,
    input  logic [Q_W-1:0]    load_val,
`endif
    output logic [Q_W-1:0]    q,
    output logic              tc,
    output logic              busy,
    output logic              done,
    input  logic              done_ack
);

    localparam logic [Q_W-1:0] c_max = Q_W'(MODULUS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WRAP_W-1:0] r_wc;
    logic [WRAP_W-1:0] r_tgt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_tgt_ld;
    logic              w_wc_clr;
    logic              w_en;
    logic              w_clr;
    logic              w_load;
    logic [Q_W-1:0]    w_load_val;
    logic              w_wrap;
    logic              w_at_max;
    logic              w_last;

`ifdef CNTR12_LOAD_EN
    logic w_load_req;
    assign w_load_req = load;
    assign w_load_val = load_val;
`else
    logic w_load_req;
    assign w_load_req = 1'b0;
    assign w_load_val = '0;
`endif

    mod_n_counter #(
        .MODULUS (MODULUS),
        .Q_W     (Q_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (w_en),
        .clr      (w_clr),
        .load     (w_load),
        .load_val (w_load_val),
        .q        (q),
        .wrap     (w_wrap)
    );

    assign w_at_max = (q == c_max);
    assign w_last   = ((r_wc + WRAP_W'(1)) == r_tgt);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_tgt_ld    = 1'b0;
        w_wc_clr    = 1'b0;
        w_en        = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr = 1'b1;
                    if (num_wraps != '0) begin
                        w_tgt_ld    = 1'b1;
                        w_wc_clr    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else if (w_load_req) begin
                    w_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_wc_clr    = 1'b1;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else if (w_load_req) begin
                    w_load = 1'b1;
                end else if (step) begin
                    w_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (done_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Terminal count on the last requested wrap ends the run
        if (w_en && w_at_max && w_last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_wc    <= '0;
            r_tgt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_tgt_ld) begin
                r_tgt <= num_wraps;
            end
            if (w_wc_clr) begin
                r_wc <= '0;
            end else if (w_wrap) begin
                r_wc <= r_wc + WRAP_W'(1);
            end
        end
    end

    assign busy = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign tc   = busy && w_at_max;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cntr12_ctrl.sv
// ============================================================================
// Module      : tb_cntr12_ctrl
// Description : Self-checking bench for cntr12_ctrl using a behavioural model
//               and an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cntr12_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, step, done_ack;
    logic [7:0] num_wraps;
    logic [3:0] q;
    logic       tc, busy, done;
`ifdef CNTR12_LOAD_EN
    logic       load;
    logic [3:0] load_val;
`endif

    always #5 clk = ~clk;

    cntr12_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .num_wraps (num_wraps),
`ifdef CNTR12_LOAD_EN
        .load      (load),
        .load_val  (load_val),
`endif
        .q         (q),
        .tc        (tc),
        .busy      (busy),
        .done      (done),
        .done_ack  (done_ack)
    );

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
    int   m_st, m_q, m_wc, m_tgt;
    logic m_done;

    function automatic obs_t m_obs();
        obs_t o;
        o.q    = 4'(m_q);
        o.busy = (m_st == 1) || (m_st == 2);
        o.tc   = o.busy && (m_q == 11);
        o.done = m_done;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.q    = q;
        o.tc   = tc;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    task automatic m_reset();
        m_st = 0; m_q = 0; m_wc = 0; m_tgt = 0; m_done = 1'b0;
    endtask

    task automatic m_inc();
        if (m_q == 11) begin
            m_q = 0;
            m_wc++;
            if (m_wc == m_tgt) begin
                m_st   = 3;
                m_done = 1'b1;
            end
        end else begin
            m_q++;
        end
    endtask

    // Drive one edge of commands, advance the model and queue its expectation
    task automatic tick(input logic st, input logic sp, input logic sg,
                        input logic ack, input int ld);
        start = st; stop = sp; step = sg; done_ack = ack;
`ifdef CNTR12_LOAD_EN
        load     = (ld >= 0);
        load_val = (ld >= 0) ? 4'(ld) : 4'd0;
`endif
        case (m_st)
            0: begin
                if (st) begin
                    if (num_wraps != 0) begin
                        m_tgt = int'(num_wraps); m_wc = 0; m_q = 0; m_st = 1;
                    end else begin
                        m_st = 3; m_done = 1'b1;
                    end
                end else if (ld >= 0) begin
                    m_q = (ld > 11) ? 11 : ld;
                end
            end
            1: begin
                if (sp) m_st = 2;
                else    m_inc();
            end
            2: begin
                if (sp) begin
                    m_st = 0; m_q = 0; m_wc = 0;
                end else if (st) begin
                    m_st = 1;
                end else if (ld >= 0) begin
                    m_q = (ld > 11) ? 11 : ld;
                end else if (sg) begin
                    m_inc();
                end
            end
            default: begin
                if (ack) begin
                    m_done = 1'b0; m_st = 0;
                end
            end
        endcase
        sb.push_back(m_obs());
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; step = 1'b0; done_ack = 1'b0;
`ifdef CNTR12_LOAD_EN
        load = 1'b0;
`endif
    endtask

    task automatic test_reset();
        obs_t e, a;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got q=%0d tc=%b busy=%b done=%b, want 0 0 0 0", q, tc, busy, done);
        end
        reset = 1'b1;
        m_reset();
        // Run to q=7 in the second wrap, then pull reset asynchronously
        num_wraps = 8'd2;
        for (int i = 0; i < 20; i++) begin
            tick(i == 0, 1'b0, 1'b0, 1'b0, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL reset_prerun[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got q=%0d tc=%b busy=%b done=%b, want 0 0 0 0", q, tc, busy, done);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        m_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                         i, a.q, a.busy, a.done, e.q, e.busy, e.done);
            end
        end
    endtask

    task automatic test_normal_run();
        obs_t e, a;
        int   tc_cnt = 0;
        num_wraps = 8'd2;
        for (int i = 0; i < 28; i++) begin
            tick(i == 0, 1'b0, 1'b0, i >= 25, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL normal_run[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
            if (tc === 1'b1) tc_cnt++;
            if (i == 24) begin
                n_cmp++;
                if (done !== 1'b1 || q !== 4'd0) begin
                    n_err++;
                    $display("FAIL normal_done_edge24: got done=%b q=%0d, want done=1 q=0", done, q);
                end
            end
        end
        n_cmp++;
        if (tc_cnt != 2) begin
            n_err++;
            $display("FAIL normal_tc_count: got %0d, want 2", tc_cnt);
        end
    endtask

    task automatic test_pause_resume();
        obs_t e, a;
        num_wraps = 8'd1;
        for (int i = 0; i < 19; i++) begin
            tick(i == 0 || i == 10, i == 6, 1'b0, i == 18, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL pause_resume[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
            if (i == 11) begin
                n_cmp++;
                if (q !== 4'd6) begin
                    n_err++;
                    $display("FAIL pause_resume_at6: got q=%0d, want 6", q);
                end
            end
            if (i == 17) begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_err++;
                    $display("FAIL pause_done_12edges: got done=%b, want 1", done);
                end
            end
        end
    endtask

    task automatic test_step_abort();
        obs_t e, a;
        int   done_seen = 0;
        num_wraps = 8'd1;
        for (int i = 0; i < 15; i++) begin
            tick(i == 0, i == 11, i == 12 || i == 13, i == 14, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL step[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
            if (i == 12) begin
                n_cmp++;
                if (q !== 4'd11 || tc !== 1'b1) begin
                    n_err++;
                    $display("FAIL step_to_11: got q=%0d tc=%b, want q=11 tc=1", q, tc);
                end
            end
        end
        num_wraps = 8'd3;
        for (int i = 0; i < 9; i++) begin
            tick(i == 0, i == 4 || i == 5 || i == 8, i == 7, 1'b0, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL abort[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
            if (done === 1'b1) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0 || q !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_final: got done_cycles=%0d q=%0d busy=%b, want 0 0 0", done_seen, q, busy);
        end
    endtask

    task automatic test_edge_cases();
        obs_t e, a;
        int   busy_seen = 0;
        num_wraps = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick(i <= 1, i == 1, i == 1, i >= 2, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL zero_wraps[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
            if (busy === 1'b1) busy_seen++;
        end
        n_cmp++;
        if (busy_seen != 0) begin
            n_err++;
            $display("FAIL zero_wraps_busy: got %0d busy cycles, want 0", busy_seen);
        end
        num_wraps = 8'd2;
        for (int i = 0; i < 6; i++) begin
            tick(i == 0 || i == 4, i == 3 || i == 4, 1'b0, 1'b0, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL start_stop_pause[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic test_max_wraps();
        obs_t e, a;
        int   tc_cnt = 0;
        num_wraps = 8'd255;
        for (int i = 0; i < 255 * 12 + 2; i++) begin
            tick(i == 0, 1'b0, 1'b0, i == 255 * 12 + 1, -1);
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL max_wraps[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
            if (tc === 1'b1) tc_cnt++;
        end
        n_cmp++;
        if (tc_cnt != 255) begin
            n_err++;
            $display("FAIL max_wraps_tc: got %0d, want 255", tc_cnt);
        end
    endtask

`ifdef CNTR12_LOAD_EN
    task automatic test_load();
        obs_t e, a;
        num_wraps = 8'd1;
        // IDLE load, start clears, pause, load 9, load 14, load+step, abort
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: tick(1'b0, 1'b0, 1'b0, 1'b0, 6);
                1: tick(1'b1, 1'b0, 1'b0, 1'b0, -1);
                2: tick(1'b0, 1'b1, 1'b0, 1'b0, -1);
                3: tick(1'b0, 1'b0, 1'b0, 1'b0, 9);
                4: tick(1'b0, 1'b0, 1'b0, 1'b0, 14);
                5: tick(1'b0, 1'b0, 1'b1, 1'b0, 3);
                6: tick(1'b0, 1'b0, 1'b1, 1'b0, -1);
                default: tick(1'b0, 1'b1, 1'b0, 1'b0, -1);
            endcase
            e = sb.pop_front(); a = dut_obs(); n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL load[%0d]: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                         i, a.q, a.tc, a.busy, a.done, e.q, e.tc, e.busy, e.done);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; done_ack = 1'b0;
        num_wraps = 8'd0;
`ifdef CNTR12_LOAD_EN
        load = 1'b0; load_val = 4'd0;
`endif
        m_reset();
        test_reset();
        test_normal_run();
        test_pause_resume();
        test_step_abort();
        test_edge_cases();
        test_max_wraps();
`ifdef CNTR12_LOAD_EN
        test_load();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
